// File: rtl/cronometro_lap_ctrl.sv
// Stopwatch time base (BCD MM:SS:CC) and lap-capture write sequencer
// feeding the write side of the 16-entry lap register file.
module cronometro_lap_ctrl #(
  parameter int unsigned TICKS_PER_CS = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_stop,
  input  logic        lap,
  input  logic        clear,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic [3:0]  wr_addr,
  output logic [23:0] wr_data,
  output logic        wr_en,
  output logic [4:0]  lap_count,
  output logic        full,
  output logic        busy
);

  localparam int unsigned PW = $clog2(TICKS_PER_CS);
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_CS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  state_t        state;
  logic [PW-1:0] prescaler;
  logic          lap_ok;
  logic          clr_ok;

  // Digit order from bit 0: cs units, cs tens, s units, s tens, m units, m tens.
  function automatic logic [3:0] digit_max(input int unsigned idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [23:0] n;
    logic        carry;
    n     = t;
    carry = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      if (carry) begin
        if (t[i*4 +: 4] >= digit_max(i)) begin
          n[i*4 +: 4] = '0;
        end else begin
          n[i*4 +: 4] = t[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return n;
  endfunction

  always_comb begin
    lap_ok = lap && running && (state == IDLE) && !full;
    clr_ok = clear && !running && (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prescaler <= '0;
      time_bcd  <= '0;
      running   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_en     <= 1'b0;
      lap_count <= '0;
      full      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (start_stop) begin
        running <= !running;
      end

      // Prescaler holds while stopped so a pause keeps the sub-cs fraction.
      if (clr_ok) begin
        prescaler <= '0;
        time_bcd  <= '0;
      end else if (running) begin
        if (prescaler == PS_LAST) begin
          prescaler <= '0;
          time_bcd  <= bcd_inc(time_bcd);
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end

      wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (lap_ok) begin
            state   <= SETUP;
            busy    <= 1'b1;
            wr_addr <= lap_count[3:0];
            wr_data <= time_bcd;
          end else if (clr_ok) begin
            lap_count <= '0;
            full      <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
          end
        end
        SETUP: begin
          state <= STROBE;
          wr_en <= 1'b1;
        end
        STROBE: begin
          state <= HOLD;
        end
        HOLD: begin
          state     <= IDLE;
          busy      <= 1'b0;
          lap_count <= lap_count + 5'd1;
          full      <= (lap_count == 5'd15);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cronometro_lap_ctrl.sv
// Scoreboard bench for cronometro_lap_ctrl: a cycle-count time model plus
// a queue of expected register-file writes checked on each wr_en pulse.
module tb_cronometro_lap_ctrl;

  localparam int unsigned T = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_stop = 1'b0;
  logic        lap = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] time_bcd;
  logic        running;
  logic [3:0]  wr_addr;
  logic [23:0] wr_data;
  logic        wr_en;
  logic [4:0]  lap_count;
  logic        full;
  logic        busy;

  cronometro_lap_ctrl #(.TICKS_PER_CS(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .time_bcd   (time_bcd),
    .running    (running),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_en      (wr_en),
    .lap_count  (lap_count),
    .full       (full),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  a;
    logic [23:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  total = 0;
  int  bad = 0;
  int  pulses = 0;
  int  m_cyc = 0;
  int  m_busy = 0;
  int  m_laps = 0;
  bit  m_run = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int n);
    int c, s, m;
    c = n % 360000;
    m = c / 6000;
    s = (c / 100) % 60;
    c = c % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // One clock: drive pulses, advance the model across the edge, check state.
  task automatic step(input logic ss, input logic lp, input logic cl);
    int  ob;
    bit  lap_ok;
    bit  clr_ok;
    wr_t e;
    start_stop = ss;
    lap        = lp;
    clear      = cl;
    @(posedge clk);
    ob     = m_busy;
    lap_ok = lp && m_run && (ob == 0) && (m_laps < 16);
    clr_ok = cl && !m_run && (ob == 0);
    if (ob > 0) begin
      m_busy--;
      if (m_busy == 0) m_laps++;
    end
    if (lap_ok) begin
      e.a = 4'(m_laps);
      e.d = to_bcd(m_cyc / T);
      exp_q.push_back(e);
      m_busy = 3;
    end
    if (m_run) m_cyc++;
    if (clr_ok) begin
      m_cyc  = 0;
      m_laps = 0;
    end
    if (ss) m_run = !m_run;
    #1;
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
    check_eq("time", time_bcd, to_bcd(m_cyc / T));
    check_eq("running", running, m_run);
    check_eq("lap_count", lap_count, m_laps);
    check_eq("full", full, m_laps == 16);
    check_eq("busy", busy, m_busy > 0);
  endtask

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      pulses++;
      check_eq("wr_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_eq("wr_addr", wr_addr, mon_e.a);
        check_eq("wr_data", wr_data, mon_e.d);
      end
    end
  end

  initial begin
    int p0;
    int guard;
    int ph;

    #12;
    check_eq("rst_time", time_bcd, 24'h000000);
    check_eq("rst_running", running, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_lap_count", lap_count, 0);
    check_eq("rst_full", full, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;
    step(0, 0, 0);

    // basic count
    step(1, 0, 0);
    for (int i = 0; i < 200; i++) begin
      step(0, 0, 0);
      check_eq("wr_en_idle", wr_en, 0);
    end
    check_eq("count200", time_bcd, 24'h000100);

    // three laps, then capture at 00:12:34 with lap_count 3
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0);
      repeat (3) step(0, 0, 0);
    end
    guard = 0;
    while ((m_cyc / T) != 1234 && guard < 5000) begin
      step(0, 0, 0);
      guard++;
    end
    check_eq("pre_lap_time", time_bcd, 24'h001234);
    check_eq("pre_lap_count", lap_count, 3);
    step(0, 1, 0);
    check_eq("t1_addr", wr_addr, 3);
    check_eq("t1_data", wr_data, 24'h001234);
    check_eq("t1_wr_en", wr_en, 0);
    check_eq("t1_busy", busy, 1);
    step(0, 0, 0);
    check_eq("t2_wr_en", wr_en, 1);
    check_eq("t2_addr", wr_addr, 3);
    check_eq("t2_data", wr_data, 24'h001234);
    step(0, 0, 0);
    check_eq("t3_wr_en", wr_en, 0);
    check_eq("t3_data", wr_data, 24'h001234);
    step(0, 0, 0);
    check_eq("t4_lap_count", lap_count, 4);
    check_eq("t4_busy", busy, 0);

    // clear while running ignored; lap + start_stop; clear + start_stop
    step(0, 0, 1);
    check_eq("clr_run_laps", lap_count, 4);
    step(1, 1, 0);
    check_eq("lapstop_running", running, 0);
    check_eq("lapstop_addr", wr_addr, 4);
    repeat (4) step(0, 0, 0);
    check_eq("lapstop_count", lap_count, 5);
    step(1, 0, 1);
    check_eq("clrstart_time", time_bcd, 24'h000000);
    check_eq("clrstart_laps", lap_count, 0);
    check_eq("clrstart_addr", wr_addr, 0);
    check_eq("clrstart_data", wr_data, 0);
    check_eq("clrstart_running", running, 1);

    // fill all 16 entries, with a dropped lap 2 cycles after each accepted one
    p0 = pulses;
    for (int i = 0; i < 18; i++) begin
      step(0, 1, 0);
      step(0, 0, 0);
      step(0, 1, 0);
      step(0, 0, 0);
    end
    repeat (4) step(0, 0, 0);
    check_eq("pulse_count", pulses - p0, 16);
    check_eq("full_flag", full, 1);
    check_eq("full_count", lap_count, 16);

    // stop, clear, restart: next lap goes to address 0
    step(1, 0, 0);
    step(0, 0, 1);
    check_eq("clr_time", time_bcd, 24'h000000);
    check_eq("clr_laps", lap_count, 0);
    check_eq("clr_full", full, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    check_eq("after_clr_addr", wr_addr, 0);
    repeat (4) step(0, 0, 0);

    // wrap from 59:59:99
    ph = m_cyc % T;
    force dut.time_bcd = 24'h595999;
    #2;
    release dut.time_bcd;
    m_cyc = 359999 * T + ph;
    repeat (T - ph) step(0, 0, 0);
    check_eq("wrap", time_bcd, 24'h000000);
    repeat (4) step(0, 0, 0);
    check_eq("after_wrap", time_bcd, 24'h000002);

    // reset during STROBE
    step(0, 1, 0);
    step(0, 0, 0);
    check_eq("strobe_high", wr_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_wr_en", wr_en, 0);
    check_eq("rst_mid_busy", busy, 0);
    check_eq("rst_mid_time", time_bcd, 24'h000000);
    check_eq("rst_mid_addr", wr_addr, 0);
    check_eq("rst_mid_data", wr_data, 0);
    check_eq("rst_mid_running", running, 0);
    exp_q.delete();
    m_cyc  = 0;
    m_busy = 0;
    m_laps = 0;
    m_run  = 1'b0;
    #10;
    rst_n = 1'b1;
    repeat (4) step(0, 0, 0);
    check_eq("post_rst_laps", lap_count, 0);

    check_eq("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cronometro_lap_ctrl.md
# cronometro_lap_ctrl

Stopwatch time base and lap-capture controller for the cronometro design. It keeps the running time as a 24-bit BCD value (MM:SS:CC). On each lap request it produces a gated write sequence (address, data, strobe) that drives the write side of the 16-entry lap register file. It sits directly upstream of that register file: `wr_addr`, `wr_data` and `wr_en` connect to its `address`, `data_in` and `wclk`.

## Interface
- `TICKS_PER_CS`, default 500000: clock cycles per centisecond (50 MHz clock). Must be ≥ 2.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start_stop`  in  1  one-cycle pulse, synchronous and debounced; toggles `running`.
- `lap`  in  1  one-cycle pulse; requests capture of the current time.
- `clear`  in  1  one-cycle pulse; zeroes the time and the lap memory index.
- `time_bcd`  out  24  live time. [23:20] min tens 0–5, [19:16] min units, [15:12] sec tens 0–5, [11:8] sec units, [7:4] cs tens, [3:0] cs units.
- `running`  out  1  stopwatch counting.
- `wr_addr`  out  4  register file address.
- `wr_data`  out  24  captured lap time.
- `wr_en`  out  1  write strobe, ANDed into the register file clock.
- `lap_count`  out  5  laps stored, 0–16.
- `full`  out  1  `lap_count` == 16.
- `busy`  out  1  write FSM not in IDLE.

## Operation
- **Reset:** all outputs 0, prescaler 0, FSM = IDLE.
- **Prescaler** counts 0..TICKS_PER_CS-1 only while `running`.
  - At TICKS_PER_CS-1 it returns to 0 and issues a tick.
  - It holds its value while stopped, so pause/resume keeps the sub-centisecond fraction.
- **Tick** increments `time_bcd` as a BCD cascade: cs 99→00 carries into sec; sec 59→00 carries into min; 59:59:99 wraps to 00:00:00. No digit ever holds a non-BCD value.
- **`start_stop`** toggles `running` at any time.
- **`clear`**
  - Accepted only when `running`=0 and FSM = IDLE.
  - Zeroes `time_bcd`, prescaler, `lap_count`, `full`, `wr_addr` and `wr_data`.
  - Otherwise it is ignored (dropped, not queued).
- **`lap`**
  - Accepted only when `running`=1 (value before this edge), FSM = IDLE and `full`=0. Otherwise dropped.
  - `time_bcd` is sampled at the same edge, before any tick of that edge is applied.
- **Write FSM states:**
  - IDLE: `wr_en`=0.
  - SETUP: `wr_addr` ← `lap_count[3:0]`, `wr_data` ← sampled time; `wr_en`=0.
  - STROBE: `wr_en`=1.
  - HOLD: `wr_en`=0, address and data held.
  - IDLE is re-entered with `lap_count` incremented.
- **Transitions:** IDLE→SETUP on an accepted lap; then SETUP→STROBE→HOLD→IDLE unconditionally.
- `wr_addr` and `wr_data` remain stable from SETUP until the next accepted lap or clear. This gives one stable cycle before and after the strobe, which the gated write clock requires.
- The time counter keeps running during the FSM sequence. The captured value is not affected.
- **Simultaneous events:**
  - `lap` + `start_stop` while running: the lap is accepted with the current time, and `running` goes to 0.
  - `clear` + `start_stop` while stopped: clear is accepted and `running` goes to 1. Counting begins from zero.
  - `clear` + `lap`: at most one can qualify, since they require opposite `running` states.
- **Reset mid-sequence:** `rst_n` low aborts the FSM immediately and `wr_en` drops asynchronously. The partially captured lap is discarded.

## Timing
- `running` changes 1 cycle after a `start_stop` pulse.
- First centisecond increment: TICKS_PER_CS cycles after `running` rises from prescaler 0.
- Lap accepted at edge t:
  - t+1: SETUP, `busy`=1.
  - t+2: `wr_en`=1.
  - t+3: `wr_en`=0.
  - t+4: IDLE, `lap_count`+1, `busy`=0.
  - The next lap can be accepted at edge t+4.
- Maximum lap rate: one per 4 cycles.
- `wr_en` is a registered output, high for exactly 1 cycle per accepted lap.
- `full` asserts in the same cycle that `lap_count` becomes 16.

## Test plan
- **Reset and basic count:** TICKS_PER_CS=2; reset, pulse `start_stop`, run 200 cycles → `time_bcd`=24'h000100 (00:01:00); `running`=1 and `wr_en`=0 throughout.
- **Wrap:** preload by running to 59:59:99, apply 1 tick → `time_bcd`=24'h000000, then counting continues.
- **Lap capture:** lap at `time_bcd`=24'h001234 with `lap_count`=3 → `wr_addr`=3 and `wr_data`=24'h001234 from t+1. `wr_en` is high only at t+2, data stays stable t+1..t+3, and `lap_count`=4 at t+4.
- **Full and dropped laps:** issue 16 laps, then 2 more → exactly 16 `wr_en` pulses, addresses 0..15, `full`=1. A lap 2 cycles after an accepted one also produces no pulse.
- **Clear rules:** clear while running → no change. Stop, then clear → `time_bcd`=0, `lap_count`=0, `full`=0, and the next lap writes address 0.
- **Reset mid-sequence:** assert `rst_n`=0 during STROBE → `wr_en` drops at once; all outputs are 0 and `lap_count` stays 0 after release.
